serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor: captures a minuend, subtrahend and borrow-in on a start strobe, then resolves the difference LSB-first through a single 1-bit full-subtractor cell and a registered borrow, one bit per clock. It is the subtract-direction counterpart to the 1-bit full adder in the arithmetic lab set, and it is the block that cell gets reused in sequentially. Results are presented in parallel with a one-cycle done pulse, for use by downstream lab blocks (counters, BCD/display paths).

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- sys_clk  input  1  system clock; all logic rising-edge.
- sys_rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- in_1  input  WIDTH  minuend; sampled on accepted start.
- in_2  input  WIDTH  subtrahend; sampled on accepted start.
- bin  input  1  borrow-in; sampled on accepted start.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  one-cycle pulse; diff/bout are valid and newly updated.
- diff  output  WIDTH  difference result; holds until the next done.
- bout  output  1  borrow-out of the MSB; holds until the next done.

## Operation
- Function: {bout, diff} = in_1 − in_2 − bin, modulo 2^(WIDTH+1). bout=1 iff in_1 < in_2 + bin (unsigned).
- Per-bit cell, with a/b the current LSBs of the operand shift registers and br the borrow register:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
- FSM states:
  - IDLE:
    - busy=0, done=0.
    - start=1: load the operand shift registers from in_1/in_2, br←bin, bit counter←0, go to SHIFT.
    - start=0: stay.
  - SHIFT: each cycle:
    - Shift both operands right by one.
    - Shift d into the MSB of the internal result register (right shift).
    - br←br_next, counter++.
    - When counter == WIDTH−1 (last bit): copy the completed result to diff, br_next to bout, go to DONE.
  - DONE:
    - done=1 for exactly this cycle.
    - Go to IDLE unconditionally.
- start outside IDLE (SHIFT or DONE) is ignored. It is not queued.
- Operand inputs may change freely after the accepting edge; only the captured copies are used.
- diff/bout change only on the transition into DONE. During SHIFT they hold the previous result.
- Reset (any state, including mid-SHIFT):
  - Next edge: state=IDLE, busy=0, done=0, diff=0, bout=0, br=0, counter=0, internal shift registers=0.
  - Reset takes priority over a simultaneous start.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0.
- Let edge k be the edge that samples start=1 in IDLE.
  - After edge k: state SHIFT, busy=1.
  - Edges k+1..k+WIDTH perform the WIDTH bit steps.
  - After edge k+WIDTH: state DONE, done=1, diff/bout valid, busy=1.
  - After edge k+WIDTH+1: IDLE, done=0, busy=0.
- Latency from start-sample edge to done high: WIDTH edges.
- Next start is accepted at edge k+WIDTH+2 at the earliest, giving a throughput of one operation per WIDTH+2 cycles.
- Holding start high continuously therefore gives back-to-back operations spaced WIDTH+2 cycles apart.
- Bit counter width: ceil(log2(WIDTH)), minimum 1 bit.

## Test plan
- After reset, WIDTH=8, in_1=100, in_2=37, bin=0, start one cycle -> done exactly 8 edges later; diff=63 (0x3F), bout=0; busy high for 9 cycles.
- in_1=5, in_2=9, bin=0 -> diff=0xFC, bout=1. Then in_1=0, in_2=0, bin=1 -> diff=0xFF, bout=1. Then in_1=0xFF, in_2=0xFF, bin=1 -> diff=0xFF, bout=1.
- Start accepted with 100−37. Pulse start with in_1=1, in_2=0 during SHIFT and again during DONE -> only one done; diff=63; no second operation begins.
- Start 100−37. Assert sys_rst on the 4th SHIFT cycle together with start=1 -> next cycle busy=0, done=0, diff=0, bout=0, and no done afterwards. A fresh start 20−3−1 -> diff=16, bout=0.
- start held high for 3 operations -> done pulses spaced exactly 10 cycles apart; diff holds the previous result between pulses.
- 1000 random in_1/in_2/bin triples, checked against the {bout,diff} = in_1−in_2−bin model at each done. Repeat at WIDTH=2 and WIDTH=16.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial N-bit subtractor. LSB-first, one full-subtractor
//               step per clock, parallel result with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_op1_q,   w_op1_d;
    logic [WIDTH-1:0]   r_op2_q,   w_op2_d;
    logic [WIDTH-1:0]   r_res_q,   w_res_d;
    logic [WIDTH-1:0]   r_diff_q,  w_diff_d;
    logic               r_bout_q,  w_bout_d;
    logic               r_br_q,    w_br_d;
    logic [c_cnt_w-1:0] r_cnt_q,   w_cnt_d;

    logic               w_a;
    logic               w_b;
    logic               w_d_bit;
    logic               w_br_next;

    // Full-subtractor cell shared by every bit position
    assign w_a       = r_op1_q[0];
    assign w_b       = r_op2_q[0];
    assign w_d_bit   = w_a ^ w_b ^ r_br_q;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br_q);

    always_comb begin
        w_state_d = r_state_q;
        w_op1_d   = r_op1_q;
        w_op2_d   = r_op2_q;
        w_res_d   = r_res_q;
        w_diff_d  = r_diff_q;
        w_bout_d  = r_bout_q;
        w_br_d    = r_br_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_op1_d   = in_1;
                    w_op2_d   = in_2;
                    w_br_d    = bin;
                    w_cnt_d   = '0;
                    w_state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_op1_d = {1'b0, r_op1_q[WIDTH-1:1]};
                w_op2_d = {1'b0, r_op2_q[WIDTH-1:1]};
                w_res_d = {w_d_bit, r_res_q[WIDTH-1:1]};
                w_br_d  = w_br_next;
                w_cnt_d = r_cnt_q + c_cnt_one;
                if (r_cnt_q == c_cnt_last) begin
                    // Publish the result directly from this step's shifted value
                    w_diff_d  = {w_d_bit, r_res_q[WIDTH-1:1]};
                    w_bout_d  = w_br_next;
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q <= S_IDLE;
            r_op1_q   <= '0;
            r_op2_q   <= '0;
            r_res_q   <= '0;
            r_diff_q  <= '0;
            r_bout_q  <= 1'b0;
            r_br_q    <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_op1_q   <= w_op1_d;
            r_op2_q   <= w_op2_d;
            r_res_q   <= w_res_d;
            r_diff_q  <= w_diff_d;
            r_bout_q  <= w_bout_d;
            r_br_q    <= w_br_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign busy = (r_state_q != S_IDLE);
    assign done = (r_state_q == S_DONE);
    assign diff = r_diff_q;
    assign bout = r_bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed-vector bench for serial_subtractor at WIDTH 2/8/16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic        sys_clk;
    logic        sys_rst;
    logic        start;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        bin;

    logic        busy8, done8, bout8;
    logic [7:0]  diff8;
    logic        busy2, done2, bout2;
    logic [1:0]  diff2;
    logic        busy16, done16, bout16;
    logic [15:0] diff16;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .in_1(in_1[7:0]), .in_2(in_2[7:0]), .bin(bin),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .in_1(in_1[1:0]), .in_2(in_2[1:0]), .bin(bin),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .in_1(in_1[15:0]), .in_2(in_2[15:0]), .bin(bin),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: {borrow, difference} of a - b - bi reduced to w+1 bits
    function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic bi);
        logic [32:0] m;
        logic [32:0] r;
        m = (33'd1 << w) - 33'd1;
        r = ({1'b0, a} & m) - ({1'b0, b} & m) - {32'd0, bi};
        return r & ((33'd1 << (w + 1)) - 33'd1);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input string tag);
        int lat;
        int bcnt;
        @(negedge sys_clk);
        in_1 = {24'd0, a}; in_2 = {24'd0, b}; bin = bi; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge sys_clk);
            lat++;
        end
        if (busy8) bcnt++;
        chk({tag, " latency"}, 33'(lat), 33'd8);
        chk({tag, " diff"}, 33'(diff8), 33'(ed));
        chk({tag, " bout"}, 33'(bout8), 33'(eb));
        @(negedge sys_clk);
        chk({tag, " done after"}, 33'(done8), 33'd0);
        chk({tag, " busy after"}, 33'(busy8), 33'd0);
        chk({tag, " busy cycles"}, 33'(bcnt), 33'd9);
        repeat (12) @(negedge sys_clk);
    endtask

    initial begin
        int ndone;
        int last_c;
        logic [7:0] bb_d [3];
        logic       bb_b [3];
        logic [31:0] ra, rb;
        logic        rbi;
        logic        s2, s8, s16;

        vecs[0] = '{8'd100, 8'd37,  1'b0, 8'h3F, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   1'b0, 8'hFC, 1'b1};
        vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF,  8'hFF,  1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'd20,  8'd3,   1'b1, 8'd16, 1'b0};
        vecs[5] = '{8'd0,   8'd1,   1'b0, 8'hFF, 1'b1};
        vecs[6] = '{8'hFF,  8'd0,   1'b0, 8'hFF, 1'b0};
        vecs[7] = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0};

        sys_rst = 1'b1; start = 1'b0; in_1 = '0; in_2 = '0; bin = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset busy", 33'(busy8), 33'd0);
        chk("reset done", 33'(done8), 33'd0);
        chk("reset diff", 33'(diff8), 33'd0);
        chk("reset bout", 33'(bout8), 33'd0);
        sys_rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run8(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].ed, vecs[i].eb,
                 $sformatf("vec%0d", i));

        // start during SHIFT and during DONE must be ignored
        @(negedge sys_clk);
        in_1 = 32'd100; in_2 = 32'd37; bin = 1'b0; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 26; c++) begin
            if (done8) ndone++;
            if (c == 3) begin start = 1'b1; in_1 = 32'd1; in_2 = 32'd0; end
            if (c == 4) start = 1'b0;
            if (c == 8) start = 1'b1;
            if (c == 9) start = 1'b0;
            @(negedge sys_clk);
        end
        chk("ignore done count", 33'(ndone), 33'd1);
        chk("ignore diff", 33'(diff8), 33'h3F);
        chk("ignore busy", 33'(busy8), 33'd0);

        // synchronous reset mid-SHIFT beats a simultaneous start
        @(negedge sys_clk);
        in_1 = 32'd100; in_2 = 32'd37; bin = 1'b0; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1; start = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0; start = 1'b0;
        chk("rst busy", 33'(busy8), 33'd0);
        chk("rst done", 33'(done8), 33'd0);
        chk("rst diff", 33'(diff8), 33'd0);
        chk("rst bout", 33'(bout8), 33'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (done8) ndone++;
        end
        chk("rst no done", 33'(ndone), 33'd0);
        run8(8'd20, 8'd3, 1'b1, 8'd16, 1'b0, "post-rst");

        // start held high: three back-to-back operations
        bb_d[0] = 8'h3F; bb_b[0] = 1'b0;
        bb_d[1] = 8'hFC; bb_b[1] = 1'b1;
        bb_d[2] = 8'd16; bb_b[2] = 1'b0;
        @(negedge sys_clk);
        in_1 = 32'd100; in_2 = 32'd37; bin = 1'b0; start = 1'b1;
        ndone = 0; last_c = 0;
        for (int c = 0; c < 60 && ndone < 3; c++) begin
            @(negedge sys_clk);
            if (done8) begin
                chk($sformatf("b2b%0d diff", ndone), 33'(diff8), 33'(bb_d[ndone]));
                chk($sformatf("b2b%0d bout", ndone), 33'(bout8), 33'(bb_b[ndone]));
                if (ndone > 0) chk($sformatf("b2b%0d spacing", ndone), 33'(c - last_c), 33'd10);
                last_c = c;
                ndone++;
                if (ndone == 1) begin in_1 = 32'd5;  in_2 = 32'd9; bin = 1'b0; end
                if (ndone == 2) begin in_1 = 32'd20; in_2 = 32'd3; bin = 1'b1; end
                if (ndone == 3) start = 1'b0;
            end else if (ndone > 0 && c - last_c == 9) begin
                chk($sformatf("b2b hold%0d", ndone), 33'({bout8, diff8}),
                    33'({bb_b[ndone-1], bb_d[ndone-1]}));
            end
        end
        start = 1'b0;
        chk("b2b done count", 33'(ndone), 33'd3);
        repeat (20) @(negedge sys_clk);

        // random operands, all three widths checked against the model
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
            @(negedge sys_clk);
            in_1 = ra; in_2 = rb; bin = rbi; start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
            s2 = 1'b0; s8 = 1'b0; s16 = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (done2 && !s2) begin
                    s2 = 1'b1;
                    chk($sformatf("rand w2 %0h-%0h-%0h", ra[1:0], rb[1:0], rbi),
                        33'({bout2, diff2}), model(2, ra, rb, rbi));
                end
                if (done8 && !s8) begin
                    s8 = 1'b1;
                    chk($sformatf("rand w8 %0h-%0h-%0h", ra[7:0], rb[7:0], rbi),
                        33'({bout8, diff8}), model(8, ra, rb, rbi));
                end
                if (done16 && !s16) begin
                    s16 = 1'b1;
                    chk($sformatf("rand w16 %0h-%0h-%0h", ra[15:0], rb[15:0], rbi),
                        33'({bout16, diff16}), model(16, ra, rb, rbi));
                end
                @(negedge sys_clk);
            end
            if (!(s2 && s8 && s16))
                chk($sformatf("rand %0d done seen", n), 33'({s16, s8, s2}), 33'd7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
